// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-unit state encoding, opcode constants
// and small opcode classification helpers.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Two-operand ALU ops that write a single result register
    function automatic logic is_alu(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // Ops producing a LO/HI result pair
    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/reg_sel_decode.sv
// Register-file select decoder: 4-bit register index to 16-bit one-hot,
// all zeros when not enabled.
module reg_sel_decode (
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [15:0] sel
);

    // One-hot decode gated by enable
    always_comb begin
        sel = '0;
        if (en) sel[idx] = 1'b1;
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: fetch (T0-T2) and execute (T3-T6) sequencing
// with datapath strobe generation.  Optional MUL/DIV sequencing is enabled
// by defining CONTROL_UNIT_MULDIV_EN; otherwise MUL/DIV decode as illegal.
module control_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic        pc_out,
    output logic        zlo_out,
    output logic        zhi_out,
    output logic        mdr_out,
    output logic        mar_enable,
    output logic        z_enable,
    output logic        pc_enable,
    output logic        mdr_enable,
    output logic        read,
    output logic        ir_enable,
    output logic        y_enable,
    output logic        pc_increment,
    output logic        lo_enable,
    output logic        hi_enable,
    output logic [4:0]  op_code,
    output logic [15:0] r_in,
    output logic [15:0] r_out,
    output logic        halted,
    output logic        illegal,
    output logic [3:0]  state_o
);

`ifdef CONTROL_UNIT_MULDIV_EN
    localparam logic MULDIV_EN = 1'b1;
`else
    localparam logic MULDIV_EN = 1'b0;
`endif

    state_t     state, next_state;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       alu_op, muldiv_op;
    logic       halt_set, illegal_set;
    logic       halted_q, illegal_q;
    logic       rin_en, rout_en;
    logic [3:0] rin_idx, rout_idx;
    logic       ir_unused;

    assign op        = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign ir_unused = ^ir[14:0];

    assign alu_op    = is_alu(op);
    assign muldiv_op = MULDIV_EN & is_muldiv(op);

    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign state_o   = state;

    // State register; clr forces IDLE asynchronously
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= S_IDLE;
        else      state <= next_state;
    end

    // Sticky halt/illegal flags, cleared only by clr
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (halt_set)    halted_q  <= 1'b1;
            if (illegal_set) illegal_q <= 1'b1;
        end
    end

    // Next-state and strobe decode from state, ir and mem_ready
    always_comb begin
        next_state   = state;
        halt_set     = 1'b0;
        illegal_set  = 1'b0;
        pc_out       = 1'b0;
        zlo_out      = 1'b0;
        zhi_out      = 1'b0;
        mdr_out      = 1'b0;
        mar_enable   = 1'b0;
        z_enable     = 1'b0;
        pc_enable    = 1'b0;
        mdr_enable   = 1'b0;
        read         = 1'b0;
        ir_enable    = 1'b0;
        y_enable     = 1'b0;
        pc_increment = 1'b0;
        lo_enable    = 1'b0;
        hi_enable    = 1'b0;
        op_code      = 5'd0;
        rin_en       = 1'b0;
        rin_idx      = 4'd0;
        rout_en      = 1'b0;
        rout_idx     = 4'd0;
        case (state)
            S_IDLE: begin
                if (run) next_state = S_T0;
            end
            S_T0: begin
                pc_out       = 1'b1;
                mar_enable   = 1'b1;
                pc_increment = 1'b1;
                z_enable     = 1'b1;
                next_state   = S_T1;
            end
            S_T1: begin
                read       = 1'b1;
                mdr_enable = 1'b1;
                zlo_out    = 1'b1;
                // The incremented PC is latched only once, when the fetch completes
                if (mem_ready) begin
                    pc_enable  = 1'b1;
                    next_state = S_T2;
                end
            end
            S_T2: begin
                mdr_out    = 1'b1;
                ir_enable  = 1'b1;
                next_state = S_T3;
            end
            S_T3: begin
                if (alu_op || muldiv_op) begin
                    rout_en    = 1'b1;
                    rout_idx   = rb;
                    y_enable   = 1'b1;
                    next_state = S_T4;
                end else if (op == OP_NOP) begin
                    next_state = run ? S_T0 : S_IDLE;
                end else if (op == OP_HALT) begin
                    halt_set   = 1'b1;
                    next_state = S_HALT;
                end else begin
                    halt_set    = 1'b1;
                    illegal_set = 1'b1;
                    next_state  = S_HALT;
                end
            end
            S_T4: begin
                rout_en    = 1'b1;
                rout_idx   = rc;
                z_enable   = 1'b1;
                op_code    = op;
                next_state = S_T5;
            end
            S_T5: begin
                zlo_out = 1'b1;
`ifdef CONTROL_UNIT_MULDIV_EN
                if (muldiv_op) begin
                    lo_enable  = 1'b1;
                    next_state = S_T6;
                end else begin
                    rin_en     = 1'b1;
                    rin_idx    = ra;
                    next_state = run ? S_T0 : S_IDLE;
                end
`else
                rin_en     = 1'b1;
                rin_idx    = ra;
                next_state = run ? S_T0 : S_IDLE;
`endif
            end
            S_T6: begin
`ifdef CONTROL_UNIT_MULDIV_EN
                zhi_out    = 1'b1;
                hi_enable  = 1'b1;
                next_state = run ? S_T0 : S_IDLE;
`else
                next_state = S_IDLE;
`endif
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    reg_sel_decode u_rin_dec (
        .idx (rin_idx),
        .en  (rin_en),
        .sel (r_in)
    );

    reg_sel_decode u_rout_dec (
        .idx (rout_idx),
        .en  (rout_en),
        .sel (r_out)
    );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: an instruction-level model expands
// each instruction into its expected per-cycle behaviour; a driver applies
// the cycle inputs and queues expectations; a monitor compares every cycle.
module tb_control_unit;
    import cpu_pkg::*;

`ifdef CONTROL_UNIT_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam logic [13:0] M_PCO   = 14'h0001;
    localparam logic [13:0] M_ZLO   = 14'h0002;
    localparam logic [13:0] M_ZHI   = 14'h0004;
    localparam logic [13:0] M_MDRO  = 14'h0008;
    localparam logic [13:0] M_MAR   = 14'h0010;
    localparam logic [13:0] M_ZEN   = 14'h0020;
    localparam logic [13:0] M_PCEN  = 14'h0040;
    localparam logic [13:0] M_MDREN = 14'h0080;
    localparam logic [13:0] M_RD    = 14'h0100;
    localparam logic [13:0] M_IREN  = 14'h0200;
    localparam logic [13:0] M_YEN   = 14'h0400;
    localparam logic [13:0] M_PCINC = 14'h0800;
    localparam logic [13:0] M_LO    = 14'h1000;
    localparam logic [13:0] M_HI    = 14'h2000;

    typedef struct {
        logic        clr;
        logic        run;
        logic        mr;
        logic [31:0] ir;
        logic [3:0]  st;
        logic [13:0] strb;
        logic [4:0]  opc;
        logic [15:0] rin;
        logic [15:0] rout;
        logic        hlt;
        logic        ill;
    } cyc_t;

    logic        clk = 1'b0;
    logic        clr, run, mem_ready;
    logic [31:0] ir;
    logic        pc_out, zlo_out, zhi_out, mdr_out, mar_enable, z_enable, pc_enable;
    logic        mdr_enable, read, ir_enable, y_enable, pc_increment, lo_enable, hi_enable;
    logic [4:0]  op_code;
    logic [15:0] r_in, r_out;
    logic        halted, illegal;
    logic [3:0]  state_o;
    logic [13:0] strb;

    cyc_t plan[$];
    cyc_t exp_q[$];
    cyc_t mon_e;
    bit   cur_idle = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir(ir),
        .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .mdr_out(mdr_out),
        .mar_enable(mar_enable), .z_enable(z_enable), .pc_enable(pc_enable),
        .mdr_enable(mdr_enable), .read(read), .ir_enable(ir_enable), .y_enable(y_enable),
        .pc_increment(pc_increment), .lo_enable(lo_enable), .hi_enable(hi_enable),
        .op_code(op_code), .r_in(r_in), .r_out(r_out), .halted(halted),
        .illegal(illegal), .state_o(state_o)
    );

    assign strb = {hi_enable, lo_enable, pc_increment, y_enable, ir_enable, read, mdr_enable,
                   pc_enable, z_enable, mar_enable, mdr_out, zhi_out, zlo_out, pc_out};

    function automatic cyc_t cyc(input logic [31:0] irv, input state_t st, input logic [13:0] s);
        cyc_t c;
        c.clr  = 1'b1;
        c.run  = 1'($urandom_range(0, 1));
        c.mr   = 1'($urandom_range(0, 1));
        c.ir   = irv;
        c.st   = st;
        c.strb = s;
        c.opc  = 5'd0;
        c.rin  = 16'd0;
        c.rout = 16'd0;
        c.hlt  = 1'b0;
        c.ill  = 1'b0;
        return c;
    endfunction

    function automatic cyc_t clr_cyc(input logic [31:0] irv);
        cyc_t c;
        c = cyc(irv, S_IDLE, 14'd0);
        c.clr = 1'b0;
        return c;
    endfunction

    // Expand one instruction into expected cycles; abort_st replaces the
    // first cycle in that state with a clr pulse (4'hF = no abort).
    task automatic add_instr(input logic [31:0] irv, input int waits, input logic run_end,
                             input logic [3:0] abort_st);
        cyc_t t[$];
        cyc_t c;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit alu, md, ends_clr;
        op  = irv[31:27];
        ra  = irv[26:23];
        rb  = irv[22:19];
        rc  = irv[18:15];
        alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
        md  = ((op == OP_MUL) || (op == OP_DIV)) && MD_EN;
        ends_clr = 1'b0;
        if (cur_idle) begin
            repeat ($urandom_range(0, 2)) begin
                c = cyc(irv, S_IDLE, 14'd0); c.run = 1'b0; t.push_back(c);
            end
            c = cyc(irv, S_IDLE, 14'd0); c.run = 1'b1; t.push_back(c);
        end
        t.push_back(cyc(irv, S_T0, M_PCO | M_MAR | M_PCINC | M_ZEN));
        for (int i = 0; i < waits; i++) begin
            c = cyc(irv, S_T1, M_RD | M_MDREN | M_ZLO); c.mr = 1'b0; t.push_back(c);
        end
        c = cyc(irv, S_T1, M_RD | M_MDREN | M_ZLO | M_PCEN); c.mr = 1'b1; t.push_back(c);
        t.push_back(cyc(irv, S_T2, M_MDRO | M_IREN));
        if (alu || md) begin
            c = cyc(irv, S_T3, M_YEN); c.rout = 16'd1 << rb; t.push_back(c);
            c = cyc(irv, S_T4, M_ZEN); c.rout = 16'd1 << rc; c.opc = op; t.push_back(c);
            if (md) begin
                t.push_back(cyc(irv, S_T5, M_ZLO | M_LO));
                c = cyc(irv, S_T6, M_ZHI | M_HI); c.run = run_end; t.push_back(c);
            end else begin
                c = cyc(irv, S_T5, M_ZLO); c.rin = 16'd1 << ra; c.run = run_end; t.push_back(c);
            end
        end else if (op == OP_NOP) begin
            c = cyc(irv, S_T3, 14'd0); c.run = run_end; t.push_back(c);
        end else begin
            t.push_back(cyc(irv, S_T3, 14'd0));
            repeat ($urandom_range(1, 4)) begin
                c = cyc(irv, S_HALT, 14'd0); c.hlt = 1'b1; c.ill = (op != OP_HALT); t.push_back(c);
            end
            t.push_back(clr_cyc(irv));
            ends_clr = 1'b1;
        end
        for (int i = 0; i < t.size(); i++) begin
            if (t[i].st == abort_st) begin
                while (t.size() > i) void'(t.pop_back());
                t.push_back(clr_cyc(irv));
                ends_clr = 1'b1;
                break;
            end
        end
        foreach (t[i]) plan.push_back(t[i]);
        cur_idle = ends_clr || !run_end;
    endtask

    // Per-cycle comparison against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            if ({state_o, strb, op_code, r_in, r_out, halted, illegal} !==
                {mon_e.st, mon_e.strb, mon_e.opc, mon_e.rin, mon_e.rout, mon_e.hlt, mon_e.ill}) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t ir=%h: got st=%h strb=%h op=%h rin=%h rout=%h hlt=%b ill=%b, want st=%h strb=%h op=%h rin=%h rout=%h hlt=%b ill=%b",
                         $time, mon_e.ir, state_o, strb, op_code, r_in, r_out, halted, illegal,
                         mon_e.st, mon_e.strb, mon_e.opc, mon_e.rin, mon_e.rout, mon_e.hlt, mon_e.ill);
            end
        end
    end

    initial begin
        logic [4:0]  rop;
        logic [31:0] rir;
        logic [3:0]  ab;
        clr = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = 32'd0;
        repeat (2) @(posedge clk);

        plan.push_back(clr_cyc(32'd0));
        add_instr(32'h521B8000, 0, 1'b0, 4'hF);
        add_instr(32'h521B8000, 3, 1'b1, 4'hF);
        add_instr({OP_ADD, 4'd2, 4'd5, 4'd9, 15'd0}, 1, 1'b0, 4'hF);
        add_instr({OP_MUL, 4'd1, 4'd2, 4'd3, 15'd0}, 1, 1'b1, 4'hF);
        add_instr({OP_DIV, 4'd6, 4'd7, 4'd8, 15'd0}, 0, 1'b0, 4'hF);
        add_instr({5'b11111, 4'd0, 4'd0, 4'd0, 15'd0}, 0, 1'b1, 4'hF);
        add_instr({OP_OR, 4'd15, 4'd0, 4'd14, 15'd0}, 2, 1'b0, 4'(S_T4));
        add_instr({OP_SUB, 4'd3, 4'd3, 4'd3, 15'd0}, 3, 1'b1, 4'(S_T1));
        add_instr({OP_NOP, 4'd0, 4'd0, 4'd0, 15'd0}, 0, 1'b1, 4'hF);
        add_instr({OP_HALT, 4'd0, 4'd0, 4'd0, 15'd0}, 1, 1'b1, 4'hF);

        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 11))
                0:       rop = OP_ADD;
                1:       rop = OP_SUB;
                2:       rop = OP_AND;
                3:       rop = OP_OR;
                4:       rop = OP_MUL;
                5:       rop = OP_DIV;
                6:       rop = OP_NOP;
                7:       rop = OP_HALT;
                8:       rop = 5'($urandom);
                default: rop = OP_ADD + 5'($urandom_range(0, 1));
            endcase
            rir = {rop, 27'($urandom)};
            ab  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 7)) : 4'hF;
            add_instr(rir, $urandom_range(0, 4), 1'($urandom_range(0, 1)), ab);
        end

        foreach (plan[i]) begin
            @(posedge clk);
            #1;
            clr       = plan[i].clr;
            run       = plan[i].run;
            mem_ready = plan[i].mr;
            ir        = plan[i].ir;
            exp_q.push_back(plan[i]);
        end
        @(posedge clk);
        #1;
        run = 1'b0;
        repeat (3) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
